tlc_phase_scheduler: RTL and testbench
======================================

Name: tlc_phase_scheduler

Overview:
- Timed, demand-responsive sequencer for a two-approach (East-West / North-South) intersection.
- Counts dwell per phase on an external timebase tick and inserts an all-red clearance between conflicting greens.
- Latches pedestrian requests, rests in EW green when NS has no demand, and handles emergency-vehicle preemption.
- Drives the lamp buses directly. It is the timing and control layer that replaces a free-running one-state-per-clock cycle.

Parameters:
- CNT_W, 8: width of the dwell counter.
- MIN_GREEN, 10: minimum ticks in any green before it may end.
- NS_GREEN, 20: fixed NS green length in ticks.
- YELLOW, 4: yellow length in ticks.
- ALL_RED, 2: all-red clearance length in ticks.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  single-cycle timebase enable; dwell counts advance only on cycles with tick=1.
- car_ns  in  1  NS vehicle detector, level.
- ped_ew  in  1  EW pedestrian button, pulse or level.
- ped_ns  in  1  NS pedestrian button, pulse or level.
- emerg_req  in  1  preemption request, level, held by the requester.
- emerg_dir  in  1  preempt direction: 0=EW, 1=NS; sampled when preemption is accepted.
- EW  out  3  lamps {G,Y,R}: 100 green, 010 yellow, 001 red.
- NS  out  3  lamps, same encoding as EW.
- walk_ew  out  1  EW walk indication.
- walk_ns  out  1  NS walk indication.
- phase  out  3  current state code, for debug and status.
- preempt_active  out  1  high in PRE_G.

Behaviour:
- States and codes: EW_G=0, EW_Y=1, AR1=2, NS_G=3, NS_Y=4, AR2=5, PRE_G=6.
- Lamps per state:
  - EW_G: EW=100, NS=001.
  - EW_Y: EW=010, NS=001.
  - AR1, AR2: both 001.
  - NS_G: EW=001, NS=100.
  - NS_Y: EW=001, NS=010.
  - PRE_G: the preempt-direction approach is 100, the other is 001.
- All outputs are registered, so lamps change in the cycle after the state register updates.
- Reset: state=AR2, cnt=0, both ped latches=0, pre_dir=0, EW=NS=001, walk_*=0, preempt_active=0, phase=5.
  - After reset the block completes a full ALL_RED before entering EW_G.
- Dwell counter: cnt is cleared on every state change. Otherwise it increments on tick and saturates at 2^CNT_W-1.
  - "Expires(D)" means tick=1 and cnt==D-1.
- Transitions, evaluated every clk:
  - EW_G -> EW_Y when cnt>=MIN_GREEN-1, tick=1, and NS demand exists (car_ns or ped_ns_latch). With no NS demand, EW_G rests indefinitely.
  - EW_Y -> AR1 on Expires(YELLOW).
  - AR1 -> NS_G on Expires(ALL_RED).
  - NS_G -> NS_Y on Expires(NS_GREEN). NS_GREEN<MIN_GREEN is treated as MIN_GREEN.
  - NS_Y -> AR2 on Expires(YELLOW).
  - AR2 -> EW_G on Expires(ALL_RED).
- Pedestrian latches:
  - ped_x_latch is set by ped_x=1 in any cycle and cleared on the cycle the matching green is entered.
  - walk_x=1 for the whole matching green only if the latch was set at entry. Otherwise walk_x=0.
  - A press during the matching green sets the latch for the next cycle of that green, not the current one.
  - Walk drops together with green on leaving the state.
- Preemption (emerg_req=1, accepted only when not already in PRE_G):
  - From a green: if emerg_dir matches the current green, go to PRE_G directly with no lamp change. Otherwise go to that green's yellow (min-green is waived).
  - Yellow states continue normally.
  - From AR1/AR2: on expiry, go to PRE_G instead of the next green.
  - pre_dir is captured on entry to PRE_G.
- PRE_G: holds while emerg_req=1, ignoring dir changes and ped/car inputs, which are still latched. On emerg_req=0, go to the yellow of pre_dir (EW_Y or NS_Y), then resume the normal sequence.
- Simultaneous events:
  - Preemption has priority over demand.
  - ped and car demand in the same cycle count as a single demand.
  - tick=0 freezes all timing but not preempt-driven green->yellow exits.
- Safety invariant: EW and NS are never both non-red in any cycle.
- rst mid-operation returns the block to the reset state on the next edge regardless of current phase.

Test Plan:
- Reset, tick every cycle, no demand -> AR2 for 2 ticks, then EW_G (EW=100, NS=001) held for 100+ ticks, phase=0.
- car_ns=1 at tick 3 of EW_G -> EW_Y after tick 10, AR1 4 ticks later, NS_G 2 ticks later, NS_G lasts 20 ticks, then NS_Y (4), AR2 (2), EW_G.
- ped_ns pulse during EW_G -> NS demand; walk_ns=1 throughout NS_G, latch clears; next NS_G has walk_ns=0. A ped_ew press during NS_G gives walk_ew=1 in the following EW_G.
- emerg_req=1, dir=1 at tick 2 of EW_G -> immediate EW_Y, AR1, PRE_G with NS=100 and preempt_active=1; drop emerg_req -> NS_Y, AR2, EW_G.
- emerg_req=1, dir=0 during EW_G -> PRE_G the next cycle with lamps unchanged. Toggle emerg_dir while held -> no change.
- Assert rst during NS_Y, and separately hold tick=0 for 50 cycles mid-NS_G -> reset state next edge; frozen lamps and cnt. Check the safety invariant on every cycle of all tests.

Source files
------------

// File: rtl/tlc_phase_scheduler.sv
// tlc_phase_scheduler
//   Timed, demand-responsive phase sequencer for a two-approach intersection
//   (East-West / North-South). Dwell in each phase is counted on an external
//   timebase tick. An all-red clearance separates conflicting greens.
//   Pedestrian requests are latched, the controller rests in EW green while
//   NS has no demand, and emergency preemption is supported.
//
// Ports
//   clk            clock
//   rst            synchronous, active-high reset
//   tick           single-cycle timebase enable for the dwell counter
//   car_ns         NS vehicle detector (level)
//   ped_ew/ped_ns  pedestrian buttons (pulse or level), latched internally
//   emerg_req      preemption request (level, held by requester)
//   emerg_dir      preempt direction, 0=EW 1=NS, sampled when accepted
//   EW, NS         lamp buses {G,Y,R}
//   walk_ew/ns     walk indications
//   phase          current state code
//   preempt_active high while in PRE_G
module tlc_phase_scheduler #(
    parameter int CNT_W     = 8,
    parameter int MIN_GREEN = 10,
    parameter int NS_GREEN  = 20,
    parameter int YELLOW    = 4,
    parameter int ALL_RED   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       car_ns,
    input  logic       ped_ew,
    input  logic       ped_ns,
    input  logic       emerg_req,
    input  logic       emerg_dir,
    output logic [2:0] EW,
    output logic [2:0] NS,
    output logic       walk_ew,
    output logic       walk_ns,
    output logic [2:0] phase,
    output logic       preempt_active
);

    typedef enum logic [2:0] {
        EW_G  = 3'd0,
        EW_Y  = 3'd1,
        AR1   = 3'd2,
        NS_G  = 3'd3,
        NS_Y  = 3'd4,
        AR2   = 3'd5,
        PRE_G = 3'd6
    } state_t;

    // A configured NS green shorter than the minimum green is stretched.
    localparam int NS_G_LEN = (NS_GREEN < MIN_GREEN) ? MIN_GREEN : NS_GREEN;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] NSG_LAST  = CNT_W'(NS_G_LEN - 1);
    localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALL_RED - 1);

    localparam logic [2:0] LAMP_G = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_R = 3'b001;

    state_t           state, nxt;
    logic [CNT_W-1:0] cnt;
    logic             pre_dir, nxt_dir;
    logic             ped_ew_latch, ped_ns_latch;
    logic             walk_ew_flag, walk_ns_flag;
    logic             ns_demand, exp_y, exp_ar, exp_nsg, min_done;
    logic             enter_ew_g, enter_ns_g;

    function automatic logic [2:0] lamp_ew(input state_t s, input logic d);
        case (s)
            EW_G:    lamp_ew = LAMP_G;
            EW_Y:    lamp_ew = LAMP_Y;
            PRE_G:   lamp_ew = d ? LAMP_R : LAMP_G;
            default: lamp_ew = LAMP_R;
        endcase
    endfunction

    function automatic logic [2:0] lamp_ns(input state_t s, input logic d);
        case (s)
            NS_G:    lamp_ns = LAMP_G;
            NS_Y:    lamp_ns = LAMP_Y;
            PRE_G:   lamp_ns = d ? LAMP_G : LAMP_R;
            default: lamp_ns = LAMP_R;
        endcase
    endfunction

    always_comb begin
        ns_demand = car_ns | ped_ns_latch;
        exp_y     = tick && (cnt == Y_LAST);
        exp_ar    = tick && (cnt == AR_LAST);
        exp_nsg   = tick && (cnt == NSG_LAST);
        min_done  = tick && (cnt >= MIN_LAST);

        nxt     = state;
        nxt_dir = pre_dir;
        case (state)
            // Preemption outranks demand and bypasses min-green and tick.
            EW_G: begin
                if (emerg_req)
                    nxt = emerg_dir ? EW_Y : PRE_G;
                else if (min_done && ns_demand)
                    nxt = EW_Y;
            end
            EW_Y:  if (exp_y)  nxt = AR1;
            AR1:   if (exp_ar) nxt = emerg_req ? PRE_G : NS_G;
            NS_G: begin
                if (emerg_req)
                    nxt = emerg_dir ? PRE_G : NS_Y;
                else if (exp_nsg)
                    nxt = NS_Y;
            end
            NS_Y:  if (exp_y)  nxt = AR2;
            AR2:   if (exp_ar) nxt = emerg_req ? PRE_G : EW_G;
            PRE_G: if (!emerg_req) nxt = pre_dir ? NS_Y : EW_Y;
            default: nxt = AR2;
        endcase

        // Direction is frozen for the whole preemption once accepted.
        if (nxt == PRE_G && state != PRE_G)
            nxt_dir = emerg_dir;

        enter_ew_g = (nxt == EW_G) && (state != EW_G);
        enter_ns_g = (nxt == NS_G) && (state != NS_G);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= AR2;
            cnt            <= '0;
            pre_dir        <= 1'b0;
            ped_ew_latch   <= 1'b0;
            ped_ns_latch   <= 1'b0;
            walk_ew_flag   <= 1'b0;
            walk_ns_flag   <= 1'b0;
            EW             <= LAMP_R;
            NS             <= LAMP_R;
            walk_ew        <= 1'b0;
            walk_ns        <= 1'b0;
            phase          <= AR2;
            preempt_active <= 1'b0;
        end else begin
            state   <= nxt;
            pre_dir <= nxt_dir;

            if (nxt != state)
                cnt <= '0;
            else if (tick && cnt != CNT_MAX)
                cnt <= cnt + 1'b1;

            // A press arriving on the entry cycle is kept for the next green.
            ped_ew_latch <= ped_ew | (ped_ew_latch & ~enter_ew_g);
            ped_ns_latch <= ped_ns | (ped_ns_latch & ~enter_ns_g);

            // Walk for a green is decided once, from the latch at entry.
            if (enter_ew_g) walk_ew_flag <= ped_ew_latch;
            if (enter_ns_g) walk_ns_flag <= ped_ns_latch;

            // Outputs follow the state register one cycle later.
            EW             <= lamp_ew(state, pre_dir);
            NS             <= lamp_ns(state, pre_dir);
            walk_ew        <= (state == EW_G) && walk_ew_flag;
            walk_ns        <= (state == NS_G) && walk_ns_flag;
            phase          <= state;
            preempt_active <= (state == PRE_G);
        end
    end

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Testbench for tlc_phase_scheduler. Expected output vectors are built from
// the phase/lamp table and pushed per cycle into a scoreboard queue; each
// cycle the registered outputs are popped and compared. Because outputs lag
// the state by one cycle, the queue holds the state sequence starting with
// the state loaded by the reset edge.
module tb_tlc_phase_scheduler;

    logic       clk = 1'b0;
    logic       rst, tick, car_ns, ped_ew, ped_ns, emerg_req, emerg_dir;
    logic [2:0] EW, NS, phase;
    logic       walk_ew, walk_ns, preempt_active;

    int         total = 0;
    int         bad   = 0;
    string      tname = "init";
    logic [13:0] sbq[$];

    localparam logic [2:0] P_EWG = 3'd0, P_EWY = 3'd1, P_AR1 = 3'd2, P_NSG = 3'd3,
                           P_NSY = 3'd4, P_AR2 = 3'd5, P_PRE = 3'd6;

    tlc_phase_scheduler dut (
        .clk(clk), .rst(rst), .tick(tick), .car_ns(car_ns),
        .ped_ew(ped_ew), .ped_ns(ped_ns), .emerg_req(emerg_req),
        .emerg_dir(emerg_dir), .EW(EW), .NS(NS), .walk_ew(walk_ew),
        .walk_ns(walk_ns), .phase(phase), .preempt_active(preempt_active)
    );

    always #5 clk = ~clk;

    // {phase, EW, NS, walk_ew, walk_ns, preempt_active}
    function automatic logic [13:0] exp_vec(input logic [2:0] ph, input logic we,
                                            input logic wn, input logic pd);
        logic [2:0] e, n;
        case (ph)
            P_EWG:   begin e = 3'b100; n = 3'b001; end
            P_EWY:   begin e = 3'b010; n = 3'b001; end
            P_NSG:   begin e = 3'b001; n = 3'b100; end
            P_NSY:   begin e = 3'b001; n = 3'b010; end
            P_PRE:   begin e = pd ? 3'b001 : 3'b100; n = pd ? 3'b100 : 3'b001; end
            default: begin e = 3'b001; n = 3'b001; end
        endcase
        return {ph, e, n, we, wn, (ph == P_PRE)};
    endfunction

    task automatic seg(input logic [2:0] ph, input int n, input logic we,
                       input logic wn, input logic pd);
        for (int i = 0; i < n; i++) sbq.push_back(exp_vec(ph, we, wn, pd));
    endtask

    task automatic check_safety();
        total++;
        assert (!(EW != 3'b001 && NS != 3'b001)) else begin
            bad++;
            $error("FAIL safety[%s] observed EW=%b NS=%b, required at least one red", tname, EW, NS);
        end
    endtask

    task automatic step();
        logic [13:0] obs, exp;
        @(posedge clk);
        #1;
        obs = {phase, EW, NS, walk_ew, walk_ns, preempt_active};
        check_safety();
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $error("FAIL underflow[%s] observed=%h required=queued entry", tname, obs);
        end else begin
            exp = sbq.pop_front();
            assert (obs === exp) else begin
                bad++;
                $error("FAIL outputs[%s] observed=%b required=%b (ph,EW,NS,wew,wns,pre)", tname, obs, exp);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_drained();
        total++;
        assert (sbq.size() == 0) else begin
            bad++;
            $error("FAIL drained[%s] observed=%0d entries left required=0", tname, sbq.size());
        end
    endtask

    task automatic do_reset();
        logic [13:0] obs;
        check_drained();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        obs = {phase, EW, NS, walk_ew, walk_ns, preempt_active};
        total++;
        assert (obs === {3'd5, 3'b001, 3'b001, 3'b000}) else begin
            bad++;
            $error("FAIL reset[%s] observed=%b required=%b", tname, obs, {3'd5, 3'b001, 3'b001, 3'b000});
        end
    endtask

    task automatic idle_inputs();
        tick = 1'b1; car_ns = 1'b0; ped_ew = 1'b0; ped_ns = 1'b0;
        emerg_req = 1'b0; emerg_dir = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();

        // Rest in EW green with no NS demand.
        tname = "rest";
        do_reset();
        seg(P_AR2, 2, 0, 0, 0);
        seg(P_EWG, 110, 0, 0, 0);
        run(112);

        // Car demand: 10 EW_G, 4 Y, 2 AR, 20 NS_G, 4 Y, 2 AR, back to EW_G.
        tname = "car";
        idle_inputs();
        do_reset();
        seg(P_AR2, 2, 0, 0, 0); seg(P_EWG, 10, 0, 0, 0); seg(P_EWY, 4, 0, 0, 0);
        seg(P_AR1, 2, 0, 0, 0); seg(P_NSG, 20, 0, 0, 0); seg(P_NSY, 4, 0, 0, 0);
        seg(P_AR2, 2, 0, 0, 0); seg(P_EWG, 20, 0, 0, 0);
        run(3);
        car_ns = 1'b1;
        run(16);
        car_ns = 1'b0;
        run(45);

        // Pedestrian latches and walk indications.
        tname = "ped";
        idle_inputs();
        do_reset();
        seg(P_AR2, 2, 0, 0, 0); seg(P_EWG, 10, 0, 0, 0); seg(P_EWY, 4, 0, 0, 0);
        seg(P_AR1, 2, 0, 0, 0); seg(P_NSG, 20, 0, 1, 0); seg(P_NSY, 4, 0, 0, 0);
        seg(P_AR2, 2, 0, 0, 0); seg(P_EWG, 10, 1, 0, 0); seg(P_EWY, 4, 0, 0, 0);
        seg(P_AR1, 2, 0, 0, 0); seg(P_NSG, 20, 0, 0, 0); seg(P_NSY, 4, 0, 0, 0);
        seg(P_AR2, 2, 0, 0, 0); seg(P_EWG, 6, 0, 0, 0);
        run(3);
        ped_ns = 1'b1;
        run(1);
        ped_ns = 1'b0;
        run(20);
        ped_ew = 1'b1;
        run(1);
        ped_ew = 1'b0;
        run(20);
        car_ns = 1'b1;
        run(15);
        car_ns = 1'b0;
        run(32);

        // Preempt toward NS from EW green: yellow, all-red, PRE_G(NS).
        tname = "pre_ns";
        idle_inputs();
        do_reset();
        seg(P_AR2, 2, 0, 0, 0); seg(P_EWG, 2, 0, 0, 0); seg(P_EWY, 4, 0, 0, 0);
        seg(P_AR1, 2, 0, 0, 0); seg(P_PRE, 10, 0, 0, 1); seg(P_NSY, 4, 0, 0, 0);
        seg(P_AR2, 2, 0, 0, 0); seg(P_EWG, 5, 0, 0, 0);
        run(3);
        emerg_req = 1'b1; emerg_dir = 1'b1;
        run(16);
        emerg_req = 1'b0;
        run(12);

        // Preempt toward EW while in EW green; direction toggles are ignored.
        tname = "pre_ew";
        idle_inputs();
        do_reset();
        seg(P_AR2, 2, 0, 0, 0); seg(P_EWG, 4, 0, 0, 0); seg(P_PRE, 10, 0, 0, 0);
        seg(P_EWY, 4, 0, 0, 0); seg(P_AR1, 2, 0, 0, 0); seg(P_NSG, 3, 0, 0, 0);
        run(5);
        emerg_req = 1'b1; emerg_dir = 1'b0;
        run(3);
        emerg_dir = 1'b1;
        run(7);
        emerg_req = 1'b0;
        run(10);

        // Reset asserted while in NS yellow.
        tname = "rst_nsy";
        idle_inputs();
        do_reset();
        car_ns = 1'b1;
        seg(P_AR2, 2, 0, 0, 0); seg(P_EWG, 10, 0, 0, 0); seg(P_EWY, 4, 0, 0, 0);
        seg(P_AR1, 2, 0, 0, 0); seg(P_NSG, 20, 0, 0, 0); seg(P_NSY, 1, 0, 0, 0);
        run(39);
        idle_inputs();
        do_reset();
        seg(P_AR2, 2, 0, 0, 0); seg(P_EWG, 3, 0, 0, 0);
        run(5);

        // tick held low for 50 cycles in NS green stretches it by 50 cycles.
        tname = "freeze";
        idle_inputs();
        do_reset();
        car_ns = 1'b1;
        seg(P_AR2, 2, 0, 0, 0); seg(P_EWG, 10, 0, 0, 0); seg(P_EWY, 4, 0, 0, 0);
        seg(P_AR1, 2, 0, 0, 0); seg(P_NSG, 70, 0, 0, 0); seg(P_NSY, 4, 0, 0, 0);
        seg(P_AR2, 2, 0, 0, 0); seg(P_EWG, 2, 0, 0, 0);
        run(19);
        car_ns = 1'b0;
        run(6);
        tick = 1'b0;
        run(50);
        tick = 1'b1;
        run(21);

        tname = "end";
        check_drained();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
